// File: rtl/hrv_pkg.sv
// Shared types and constants for the HRV RMSSD datapath.
package hrv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIFF,
        ST_UPDATE,
        ST_SQRT,
        ST_OUT
    } state_t;

    // Default geometry; instances may override through their own parameters.
    localparam int unsigned RR_W_DEF     = 12;
    localparam int unsigned LOG2_N_DEF   = 3;
    localparam int unsigned MAX_DIFF_DEF = 200;
    localparam int unsigned N            = 1 << LOG2_N_DEF;
    localparam int unsigned SQ_W         = 2 * RR_W_DEF;
    localparam int unsigned SUM_W        = SQ_W + LOG2_N_DEF;

    // Unsigned |a - b| without wrap: compare first, then subtract.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/hrv_rmssd_stream_if.sv
// RR-interval input handshake and RMSSD result bundle.
interface hrv_rmssd_stream_if #(
    parameter int unsigned RR_W = 12
) ();
    logic            clear;
    logic            rr_valid;
    logic            rr_ready;
    logic [RR_W-1:0] rr_data;
    logic            rmssd_valid;
    logic [RR_W-1:0] rmssd_data;
    logic            window_full;
    logic            artifact;

    modport master (
        output clear, rr_valid, rr_data,
        input  rr_ready, rmssd_valid, rmssd_data, window_full, artifact
    );

    modport slave (
        input  clear, rr_valid, rr_data,
        output rr_ready, rmssd_valid, rmssd_data, window_full, artifact
    );
endinterface

// File: rtl/hrv_isqrt.sv
// Restoring integer square root, one result bit per cycle.
// The start cycle already performs the first iteration, so done rises
// OUT_W cycles after start and root is valid while done is high.
module hrv_isqrt import hrv_pkg::*; #(
    parameter int unsigned IN_W  = SQ_W,
    parameter int unsigned OUT_W = RR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic [IN_W-1:0]  radicand,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] root
);
    localparam int unsigned CNT_W = $clog2(OUT_W + 1);

    logic [IN_W-1:0]  rad_q, src_rad, nxt_rad;
    logic [OUT_W+1:0] rem_q, src_rem, nxt_rem;
    logic [OUT_W-1:0] root_q, src_root, nxt_root;
    logic [OUT_W+3:0] rem_sh, trial;
    logic [CNT_W-1:0] cnt_q;

    // One restoring step on either fresh operands (start) or the running state.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        src_rad  = start ? radicand : rad_q;
        rem_sh   = {src_rem, src_rad[IN_W-1 -: 2]};
        trial    = {2'b00, src_root, 2'b01};
        nxt_rad  = src_rad << 2;
        if (rem_sh >= trial) begin
            nxt_rem  = (OUT_W + 2)'(rem_sh - trial);
            nxt_root = {src_root[OUT_W-2:0], 1'b1};
        end else begin
            nxt_rem  = (OUT_W + 2)'(rem_sh);
            nxt_root = {src_root[OUT_W-2:0], 1'b0};
        end
    end

    // Iteration sequencing and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rad_q  <= nxt_rad;
                rem_q  <= nxt_rem;
                root_q <= nxt_root;
                cnt_q  <= CNT_W'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                rad_q  <= nxt_rad;
                rem_q  <= nxt_rem;
                root_q <= nxt_root;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(OUT_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign root = root_q;

endmodule

// File: rtl/hrv_rmssd_stream.sv
// Sliding-window RMSSD over the last 2**LOG2_N squared successive RR differences.
module hrv_rmssd_stream import hrv_pkg::*; #(
    parameter int unsigned RR_W     = RR_W_DEF,
    parameter int unsigned LOG2_N   = LOG2_N_DEF,
    parameter int unsigned MAX_DIFF = MAX_DIFF_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    hrv_rmssd_stream_if.slave  s
);
    localparam int unsigned WIN_N  = 1 << LOG2_N;
    localparam int unsigned WSQ_W  = 2 * RR_W;
    localparam int unsigned WSUM_W = WSQ_W + LOG2_N;
    localparam int unsigned FILL_W = LOG2_N + 1;
    localparam logic [RR_W:0] MAX_D = (RR_W + 1)'(MAX_DIFF);

    state_t              state;
    logic [RR_W-1:0]     rr_lat, prev_q, diff;
    logic                prev_valid;
    logic [WSQ_W-1:0]    sq_q, sq_calc, old_sq;
    logic [WSQ_W-1:0]    win_buf [WIN_N];
    logic [LOG2_N-1:0]   wp_q;
    logic [FILL_W-1:0]   fill_q, fill_next;
    logic [WSUM_W-1:0]   sum_q, sum_next;
    logic [RR_W-1:0]     rmssd_q, sq_root;
    logic                rmssd_valid_q, artifact_q, full_q;
    logic                sq_start, sq_busy, sq_done;

    // Difference, square and the candidate window sum for the current sample.
    always_comb begin
        diff      = RR_W'(abs_diff(32'(rr_lat), 32'(prev_q)));
        sq_calc   = WSQ_W'(diff) * WSQ_W'(diff);
        old_sq    = (fill_q == FILL_W'(WIN_N)) ? win_buf[wp_q] : '0;
        sum_next  = sum_q + WSUM_W'(sq_q) - WSUM_W'(old_sq);
        fill_next = (fill_q == FILL_W'(WIN_N)) ? fill_q : fill_q + 1'b1;
        sq_start  = (state == ST_UPDATE) && (fill_next == FILL_W'(WIN_N));
    end

    // Squared-difference ring; stale entries are masked by the fill count.
    always_ff @(posedge clk) begin
        if (state == ST_UPDATE) begin
            win_buf[wp_q] <= sq_q;
        end
    end

    // Control FSM with registered result, pulse and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || s.clear) begin
            state         <= ST_IDLE;
            rr_lat        <= '0;
            prev_q        <= '0;
            prev_valid    <= 1'b0;
            sq_q          <= '0;
            wp_q          <= '0;
            fill_q        <= '0;
            sum_q         <= '0;
            rmssd_q       <= '0;
            rmssd_valid_q <= 1'b0;
            artifact_q    <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            rmssd_valid_q <= 1'b0;
            artifact_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s.rr_valid) begin
                        rr_lat <= s.rr_data;
                        state  <= ST_DIFF;
                    end
                end
                ST_DIFF: begin
                    if (!prev_valid) begin
                        prev_q     <= rr_lat;
                        prev_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (rr_lat == '0 || {1'b0, diff} > MAX_D) begin
                        prev_q     <= rr_lat;
                        artifact_q <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        sq_q  <= sq_calc;
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    sum_q  <= sum_next;
                    wp_q   <= wp_q + 1'b1;
                    fill_q <= fill_next;
                    prev_q <= rr_lat;
                    full_q <= (fill_next == FILL_W'(WIN_N));
                    state  <= (fill_next == FILL_W'(WIN_N)) ? ST_SQRT : ST_IDLE;
                end
                ST_SQRT: begin
                    if (sq_done && !sq_busy) begin
                        rmssd_q       <= sq_root;
                        rmssd_valid_q <= 1'b1;
                        state         <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Root of the window mean; started while the new sum is being committed.
    hrv_isqrt #(
        .IN_W  (WSQ_W),
        .OUT_W (RR_W)
    ) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (s.clear),
        .start    (sq_start),
        .radicand (WSQ_W'(sum_next >> LOG2_N)),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (sq_root)
    );

    assign s.rr_ready    = rst_n && !s.clear && (state == ST_IDLE);
    assign s.rmssd_valid = rmssd_valid_q;
    assign s.rmssd_data  = rmssd_q;
    assign s.window_full = full_q;
    assign s.artifact    = artifact_q;

endmodule

// File: tb/tb_hrv_rmssd_stream.sv
// Randomised bench for hrv_rmssd_stream against a queue-based RMSSD model.
module tb_hrv_rmssd_stream;
    localparam int unsigned RW  = 12;
    localparam int unsigned WN  = 8;
    localparam int          LAT = RW + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cur_sel = 1'b0;

    hrv_rmssd_stream_if #(.RR_W(RW)) ifa ();
    hrv_rmssd_stream_if #(.RR_W(RW)) ifb ();

    hrv_rmssd_stream #(.RR_W(RW), .LOG2_N(3), .MAX_DIFF(200)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ifa)
    );
    hrv_rmssd_stream #(.RR_W(RW), .LOG2_N(3), .MAX_DIFF(4095)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ifb)
    );

    always #5 clk = ~clk;

    logic          m_ready, m_rv, m_wf, m_art;
    logic [RW-1:0] m_data;
    assign m_ready = cur_sel ? ifb.rr_ready    : ifa.rr_ready;
    assign m_rv    = cur_sel ? ifb.rmssd_valid : ifa.rmssd_valid;
    assign m_wf    = cur_sel ? ifb.window_full : ifa.window_full;
    assign m_art   = cur_sel ? ifb.artifact    : ifa.artifact;
    assign m_data  = cur_sel ? ifb.rmssd_data  : ifa.rmssd_data;

    // Reference model: last WN squared differences kept in a queue.
    bit              pv [2];
    int unsigned     prevm [2];
    longint unsigned win_a [$];
    longint unsigned win_b [$];

    function automatic int unsigned ref_sqrt(input longint unsigned m);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= m) r++;
        return int'(r);
    endfunction

    function automatic void model_clear();
        pv[0] = 0; pv[1] = 0;
        win_a.delete(); win_b.delete();
    endfunction

    function automatic void model_push(input bit sel, input int unsigned x,
                                       output bit e_art, output bit e_out,
                                       output int unsigned e_val, output bit e_full);
        longint unsigned q[$];
        longint unsigned sum = 0;
        int unsigned d;
        int unsigned maxd = sel ? 4095 : 200;
        q = sel ? win_b : win_a;
        e_art = 0; e_out = 0; e_val = 0;
        if (!pv[sel]) begin
            pv[sel] = 1; prevm[sel] = x;
        end else begin
            d = (x > prevm[sel]) ? x - prevm[sel] : prevm[sel] - x;
            prevm[sel] = x;
            if (x == 0 || d > maxd) begin
                e_art = 1;
            end else begin
                q.push_back(longint'(d) * longint'(d));
                if (q.size() > WN) void'(q.pop_front());
                if (q.size() == WN) begin
                    foreach (q[i]) sum += q[i];
                    e_out = 1;
                    e_val = ref_sqrt(sum / WN);
                end
            end
        end
        e_full = (q.size() == WN);
        if (sel) win_b = q; else win_a = q;
    endfunction

    task automatic drive_in(input bit sel, input logic v, input int unsigned x);
        if (sel) begin ifb.rr_valid = v; ifb.rr_data = RW'(x); end
        else     begin ifa.rr_valid = v; ifa.rr_data = RW'(x); end
    endtask

    // Offers one sample, then observes the block until it is ready again.
    task automatic send(input bit sel, input int unsigned x, output bit to, output int lat,
                        output int nval, output logic [RW-1:0] data, output bit art, output bit wf);
        int k = 0;
        cur_sel = sel;
        to = 0; lat = -1; nval = 0; data = '0; art = 0; wf = 0;
        drive_in(sel, 1'b1, x);
        #1;
        while (!m_ready && k < 100) begin @(negedge clk); k++; end
        if (!m_ready) begin to = 1; drive_in(sel, 1'b0, 0); return; end
        @(negedge clk);
        drive_in(sel, 1'b0, 0);
        for (int i = 1; i <= 40; i++) begin
            if (m_rv) begin nval++; lat = i; data = m_data; end
            if (m_art) art = 1;
            if (m_ready) begin wf = m_wf; return; end
            @(negedge clk);
        end
        to = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.clear = 0; ifb.clear = 0;
        drive_in(0, 0, 0); drive_in(1, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (ifa.rr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ifa.rr_ready); end
        checks++; if ({ifa.rmssd_valid, ifa.window_full, ifa.artifact} !== 3'b000)
            begin errors++; $display("FAIL reset_flags got %b exp 000", {ifa.rmssd_valid, ifa.window_full, ifa.artifact}); end
        checks++; if (ifa.rmssd_data !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", ifa.rmssd_data); end
        rst_n = 1'b1;
        #1;
        checks++; if (ifa.rr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", ifa.rr_ready); end
        model_clear();
    endtask

    task automatic test_known_sequence();
        int unsigned seq [12] = '{800, 810, 800, 810, 800, 810, 800, 810, 800, 840, 1100, 1110};
        int unsigned cval [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 10, 16, 0, 16};
        bit to, art, wf, e_art, e_out, e_full;
        int lat, nval;
        int unsigned e_val;
        logic [RW-1:0] data;
        for (int i = 0; i < 12; i++) begin
            send(0, seq[i], to, lat, nval, data, art, wf);
            model_push(0, seq[i], e_art, e_out, e_val, e_full);
            checks++;
            if (to) begin errors++; $display("FAIL known_timeout idx %0d got no ready exp ready", i); end
            else begin
                checks++; if (art !== e_art) begin errors++; $display("FAIL known_artifact idx %0d got %b exp %b", i, art, e_art); end
                checks++; if (nval !== (e_out ? 1 : 0)) begin errors++; $display("FAIL known_valid_count idx %0d got %0d exp %0d", i, nval, e_out); end
                checks++; if (wf !== e_full) begin errors++; $display("FAIL known_full idx %0d got %b exp %b", i, wf, e_full); end
                if (cval[i] != 0) begin
                    checks++; if (data !== RW'(cval[i])) begin errors++; $display("FAIL known_value idx %0d got %0d exp %0d", i, data, cval[i]); end
                    checks++; if (lat !== LAT) begin errors++; $display("FAIL known_latency idx %0d got %0d exp %0d", i, lat, LAT); end
                end
                if (i == 10) begin
                    checks++; if (art !== 1'b1) begin errors++; $display("FAIL known_art1100 got %b exp 1", art); end
                    checks++; if (ifa.rmssd_data !== RW'(16)) begin errors++; $display("FAIL known_hold got %0d exp 16", ifa.rmssd_data); end
                end
            end
        end
    endtask

    task automatic test_random(input bit sel, input int count, input bit alt);
        bit to, art, wf, e_art, e_out, e_full;
        int lat, nval;
        int unsigned e_val, x;
        int px = 900;
        logic [RW-1:0] data;
        for (int i = 0; i < count; i++) begin
            if (alt) x = (i % 2 == 0) ? 0 : 4095;
            else if ($urandom_range(0, 19) == 0) x = 0;
            else begin
                px = px + int'($urandom_range(0, 480)) - 240;
                if (px < 300) px = 300;
                if (px > 3000) px = 3000;
                x = px;
            end
            send(sel, x, to, lat, nval, data, art, wf);
            model_push(sel, x, e_art, e_out, e_val, e_full);
            checks++;
            if (to) begin errors++; $display("FAIL rand_timeout sel %0d idx %0d got no ready exp ready", sel, i); end
            else begin
                checks++; if (art !== e_art) begin errors++; $display("FAIL rand_artifact sel %0d x %0d got %b exp %b", sel, x, art, e_art); end
                checks++; if (nval !== (e_out ? 1 : 0)) begin errors++; $display("FAIL rand_valid_count sel %0d x %0d got %0d exp %0d", sel, x, nval, e_out); end
                checks++; if (wf !== e_full) begin errors++; $display("FAIL rand_full sel %0d x %0d got %b exp %b", sel, x, wf, e_full); end
                if (e_out) begin
                    checks++; if (data !== RW'(e_val)) begin errors++; $display("FAIL rand_value sel %0d x %0d got %0d exp %0d", sel, x, data, e_val); end
                    checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency sel %0d got %0d exp %0d", sel, lat, LAT); end
                end
            end
        end
        if (alt) begin
            checks++; if (ifb.rmssd_data !== RW'(4095)) begin errors++; $display("FAIL wide_max got %0d exp 4095", ifb.rmssd_data); end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned exp_q [$];
        int exp_art = 0, got_art = 0, got_out = 0;
        int px = 1000;
        int unsigned x, e_val;
        bit e_art, e_out, e_full;
        cur_sel = 0;
        for (int c = 0; c < 700; c++) begin
            if (ifa.rmssd_valid) begin
                got_out++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_output got %0d exp none", ifa.rmssd_data); end
                else begin
                    e_val = exp_q.pop_front();
                    if (ifa.rmssd_data !== RW'(e_val)) begin errors++; $display("FAIL b2b_value got %0d exp %0d", ifa.rmssd_data, e_val); end
                end
            end
            if (ifa.artifact) got_art++;
            if (c < 600) begin
                px = px + int'($urandom_range(0, 440)) - 220;
                if (px < 300) px = 300;
                if (px > 3000) px = 3000;
                x = ($urandom_range(0, 29) == 0) ? 0 : px;
                drive_in(0, 1'b1, x);
                #1;
                if (ifa.rr_ready) begin
                    model_push(0, x, e_art, e_out, e_val, e_full);
                    if (e_art) exp_art++;
                    if (e_out) exp_q.push_back(e_val);
                end
            end else drive_in(0, 1'b0, 0);
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_outputs got %0d exp %0d more", got_out, exp_q.size()); end
        checks++; if (got_art != exp_art) begin errors++; $display("FAIL b2b_artifacts got %0d exp %0d", got_art, exp_art); end
    endtask

    task automatic test_clear_abort();
        int unsigned seq [9] = '{800, 830, 800, 830, 800, 830, 800, 830, 800};
        bit to, art, wf, e_art, e_out, e_full;
        int lat, nval, k = 0, seen = 0;
        int unsigned e_val;
        logic [RW-1:0] data;
        cur_sel = 0;
        checks++; if (ifa.window_full !== 1'b1) begin errors++; $display("FAIL clear_pre_full got %b exp 1", ifa.window_full); end
        drive_in(0, 1'b1, 810);
        #1;
        while (!ifa.rr_ready && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        drive_in(0, 1'b0, 0);
        repeat (5) @(negedge clk);
        ifa.clear = 1'b1;
        #1;
        checks++; if (ifa.rr_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b exp 0", ifa.rr_ready); end
        @(negedge clk);
        ifa.clear = 1'b0;
        checks++; if (ifa.window_full !== 1'b0) begin errors++; $display("FAIL clear_full got %b exp 0", ifa.window_full); end
        checks++; if (ifa.rmssd_data !== '0) begin errors++; $display("FAIL clear_data got %0d exp 0", ifa.rmssd_data); end
        for (int i = 0; i < 30; i++) begin
            if (ifa.rmssd_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL clear_abort_valid got %0d exp 0", seen); end
        model_clear();
        for (int i = 0; i < 9; i++) begin
            send(0, seq[i], to, lat, nval, data, art, wf);
            model_push(0, seq[i], e_art, e_out, e_val, e_full);
            checks++;
            if (to) begin errors++; $display("FAIL refill_timeout idx %0d got no ready exp ready", i); end
            else begin
                checks++; if (nval !== (i == 8 ? 1 : 0)) begin errors++; $display("FAIL refill_valid idx %0d got %0d exp %0d", i, nval, i == 8); end
                checks++; if (nval !== (e_out ? 1 : 0)) begin errors++; $display("FAIL refill_model idx %0d got %0d exp %0d", i, nval, e_out); end
                if (i == 8) begin
                    checks++; if (data !== RW'(30)) begin errors++; $display("FAIL refill_value got %0d exp 30", data); end
                end
            end
        end
    endtask

    initial begin
        ifa.clear = 0; ifb.clear = 0;
        drive_in(0, 0, 0); drive_in(1, 0, 0);
        @(negedge clk);
        test_reset();
        test_known_sequence();
        test_random(0, 60, 0);
        test_back_to_back();
        test_clear_abort();
        test_random(1, 20, 1);
        test_random(1, 30, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
